// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin sharing of one 4-bit ALU among NREQ requesters.
// Ports: clk_i/reset_i (async, active-high); req_valid_i/req_a_i/req_b_i/req_sel_i in, req_ready_o one-hot grant;
// alu_a_o/alu_b_o/alu_sel_o registered ALU inputs, alu_result_i sampled ALU_LAT cycles after the transfer;
// resp_valid_o/resp_id_o/resp_result_o with resp_ready_i; busy_o high outside IDLE.
module alu_req_scheduler #(
  parameter int NREQ = 4,
  parameter int ALU_LAT = 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [4*NREQ-1:0]   req_a_i,
  input  logic [4*NREQ-1:0]   req_b_i,
  input  logic [3*NREQ-1:0]   req_sel_i,
  output logic [NREQ-1:0]     req_ready_o,
  output logic [3:0]          alu_a_o,
  output logic [3:0]          alu_b_o,
  output logic [2:0]          alu_sel_o,
  input  logic [5:0]          alu_result_i,
  output logic                resp_valid_o,
  output logic [IDW-1:0]      resp_id_o,
  output logic [5:0]          resp_result_o,
  input  logic                resp_ready_i,
  output logic                busy_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, id_q, id_d, resp_id_q, resp_id_d, gnt;
  logic [3:0] cnt_q, cnt_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d, ga, gb;
  logic [2:0] alu_sel_q, alu_sel_d, gs;
  logic [5:0] resp_result_q, resp_result_d;
  logic [IDW:0] sum, wrap;
  logic any, xfer;
  // Scan offsets from highest to lowest so the requester closest to rr_q wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    sum = '0;
    wrap = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (IDW+1)'(k);
      wrap = (sum >= (IDW+1)'(NREQ)) ? sum - (IDW+1)'(NREQ) : sum;
      if (req_valid_i[wrap[IDW-1:0]]) begin
        gnt = wrap[IDW-1:0];
        any = 1'b1;
      end
    end
  end
  always_comb begin
    ga = '0;
    gb = '0;
    gs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        ga = req_a_i[4*i +: 4];
        gb = req_b_i[4*i +: 4];
        gs = req_sel_i[3*i +: 3];
      end
    end
  end
  // Gated by reset so the grant reads zero while reset is held.
  assign req_ready_o = (state_q == IDLE && any && !reset_i) ? NREQ'(1) << gnt : '0;
  assign xfer = |(req_valid_i & req_ready_o);
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    cnt_d = cnt_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_sel_d = alu_sel_q;
    resp_id_d = resp_id_q;
    resp_result_d = resp_result_q;
    if (state_q == IDLE && xfer) begin
      alu_a_d = ga;
      alu_b_d = gb;
      alu_sel_d = gs;
      id_d = gnt;
      rr_d = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      cnt_d = 4'(ALU_LAT - 1);
      state_d = WAIT;
    end
    if (state_q == WAIT) begin
      cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      resp_result_d = (cnt_q == 4'd0) ? alu_result_i : resp_result_q;
      resp_id_d = (cnt_q == 4'd0) ? id_q : resp_id_q;
      state_d = (cnt_q == 4'd0) ? RESP : WAIT;
    end
    if (state_q == RESP && resp_ready_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_sel_q <= '0;
      resp_id_q <= '0;
      resp_result_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      resp_id_q <= resp_id_d;
      resp_result_q <= resp_result_d;
    end
  end
  assign alu_a_o = alu_a_q;
  assign alu_b_o = alu_b_q;
  assign alu_sel_o = alu_sel_q;
  assign resp_valid_o = state_q == RESP;
  assign resp_id_o = resp_id_q;
  assign resp_result_o = resp_result_q;
  assign busy_o = state_q != IDLE;
endmodule
